slot_judge: RTL and testbench
=============================

Name: slot_judge

Overview:
- Receiving end of the slot machine's result interface.
- Watches the spin-control `mode` level and the final-digit-settled `done` flag (slot machine carry3), then latches the three settled BCD digits.
- Classifies the result (jackpot / triple / pair / none) and maintains a saturating credit balance, presented as binary and as two BCD digits for the 7-segment path.
- Sits between slot_machine and the display/LED mux in the clock top level.

Parameters:
- CREDIT_INIT, 10: credit value loaded at reset.
- CREDIT_MAX, 99: saturation ceiling; must be ≤ 99.
- PAIR_PAY, 2: credits paid when exactly two digits are equal.
- TRIPLE_PAY, 10: credits paid when all three digits are equal and not 7.
- JACKPOT_PAY, 50: credits paid for 7-7-7.
- SHOW_CYCLES, 50000000: clk cycles the result is held in SHOW (1 s at 50 MHz).
- BLINK_DIV, 12500000: half-period of blink in clk cycles (used only with the optional feature).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- mode, input, 1: spin level from slot machine; 1 = reels running; asynchronous to clk.
- done, input, 1: slot machine carry3; rises when the last reel has settled; asynchronous.
- slot_bcd1, input, 4: ones reel digit.
- slot_bcd2, input, 4: tens reel digit.
- slot_bcd3, input, 4: hundreds reel digit.
- credit, output, 7: current credit, binary.
- credit_tens, output, 4: BCD tens digit of credit.
- credit_ones, output, 4: BCD ones digit of credit.
- win_code, output, 2: 0 = none, 1 = pair, 2 = triple, 3 = jackpot.
- win_valid, output, 1: one-cycle pulse when win_code and credit update.
- busy, output, 1: high from spin accept until SHOW expires.
- no_credit, output, 1: one-cycle pulse when a spin is requested with credit = 0.
- blink, output, 1: win indicator LED.

Behaviour:
- Reset (rst=1 at a clk edge):
  - credit=CREDIT_INIT, win_code=0, win_valid=0, busy=0, no_credit=0, blink=0.
  - Latched digits=0, state=IDLE, show/blink counters=0, synchroniser flops=0.
- Input synchronisation:
  - mode and done each pass through a 2-flop synchroniser.
  - A third flop provides edge detect; mode_rise, mode_fall and done_rise are one-cycle pulses.
  - Latency from pin edge to event pulse is 3 clk cycles.
- State IDLE:
  - On mode_rise with credit>0: credit−=1, busy=1, go to SPIN.
  - On mode_rise with credit=0: pulse no_credit, stay in IDLE.
  - done_rise in IDLE is ignored.
- State SPIN:
  - done_rise goes to LATCH.
  - mode_fall before done_rise aborts: go to IDLE, busy=0, no refund, win_code unchanged.
  - mode_fall and done_rise in the same cycle: done_rise wins.
- State LATCH (1 cycle):
  - Register slot_bcd1..3. They are stable, since the reels settled ≥3 cycles earlier.
  - Go to EVAL.
- State EVAL (1 cycle):
  - Any latched digit >9 gives code 0.
  - Otherwise priority is: all three ==7 → 3; all equal → 2; any two equal → 1; else 0.
  - credit = min(credit + pay, CREDIT_MAX), computed in 8-bit to avoid overflow.
  - win_code is registered and win_valid pulses; go to SHOW.
- State SHOW:
  - Counts SHOW_CYCLES−1 down to 0, then goes to IDLE and clears busy and blink.
  - mode_rise during SHOW is dropped, not queued.
  - win_code holds until the next EVAL.
- blink without the optional feature: equals (win_code≠0) while in SHOW, else 0.
- credit_tens / credit_ones: combinational conversion of credit (credit/10, credit%10).
- rst asserted in any state returns all state to reset values, including credit.

Optional Feature:
- Macro: SLOT_JUDGE_BLINK_EN.
- Defined: during SHOW with win_code≠0, blink toggles every BLINK_DIV cycles, starting high on SHOW entry. For jackpot it toggles every BLINK_DIV/4 cycles.
- Undefined: blink is a steady level as described in Behaviour, and no blink counter is instantiated.

Decomposition:
- Package slot_pkg:
  - win_code constants WIN_NONE, WIN_PAIR, WIN_TRIPLE, WIN_JACKPOT.
  - State encoding IDLE, SPIN, LATCH, EVAL, SHOW.
  - JACKPOT_DIGIT = 7.
- Sub-module sync_edge: 2-flop synchroniser plus rising/falling pulse outputs, with rst; instantiated twice (mode, done).

Test Plan:
- Reset with CREDIT_INIT=10 → credit=10, credit_tens=1, credit_ones=0, busy=0, win_code=0.
- mode 0→1, then done 0→1 with digits 7,7,7 → credit 10→9→59; win_code=3; one win_valid pulse; busy drops after SHOW_CYCLES (bench sets SHOW_CYCLES=20).
- Digits 3,5,3 from credit 5 → credit 4→6, win_code=1; digits 1,2,4 → win_code=0 and credit only decrements.
- Credit 0 and mode rises → no_credit pulses once, state stays IDLE, credit stays 0; done then rises → no win_valid.
- mode rises then falls before done → credit decremented by 1, busy returns to 0, no win_valid; later done_rise is ignored.
- Credit 95 with digits 4,4,4 → credit saturates at 99. Separately, rst asserted mid-SPIN → credit=CREDIT_INIT, busy=0 on the next cycle.

Source files
------------

// File: rtl/slot_judge_pkg.sv
// slot_pkg: shared definitions for the slot machine result judge.
//   - win_code constants (none / pair / triple / jackpot)
//   - FSM state encoding (IDLE, SPIN, LATCH, EVAL, SHOW)
//   - JACKPOT_DIGIT and the result classification function
package slot_pkg;

  localparam logic [1:0] WIN_NONE    = 2'd0;
  localparam logic [1:0] WIN_PAIR    = 2'd1;
  localparam logic [1:0] WIN_TRIPLE  = 2'd2;
  localparam logic [1:0] WIN_JACKPOT = 2'd3;

  localparam logic [3:0] JACKPOT_DIGIT = 4'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    LATCH = 3'd2,
    EVAL  = 3'd3,
    SHOW  = 3'd4
  } state_e;

  // A non-BCD digit means the reel result is garbage, so it never pays.
  function automatic logic [1:0] classify(input logic [3:0] d1,
                                          input logic [3:0] d2,
                                          input logic [3:0] d3);
    if (d1 > 4'd9 || d2 > 4'd9 || d3 > 4'd9) return WIN_NONE;
    if (d1 == d2 && d2 == d3)
      return (d1 == JACKPOT_DIGIT) ? WIN_JACKPOT : WIN_TRIPLE;
    if (d1 == d2 || d2 == d3 || d1 == d3) return WIN_PAIR;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/slot_judge_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level, plus a third
// flop for edge detection.
//   clk, rst : clock, synchronous active-high reset (all flops to 0)
//   din      : asynchronous input level
//   rise     : one-cycle pulse after a 0->1 transition of din
//   fall     : one-cycle pulse after a 1->0 transition of din
// The pulse is visible two edges after the pin changes, so logic acting on
// it updates on the third edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/slot_judge.sv
// slot_judge: receiving end of the slot machine result interface.
// Accepts a spin on a mode rise (costs one credit), waits for the last reel
// (done rise), latches and classifies the three BCD digits, pays out into a
// saturating credit balance and holds the result for SHOW_CYCLES.
//   clk, rst              : clock, synchronous active-high reset
//   mode, done            : asynchronous spin level / last-reel-settled flag
//   slot_bcd1..3          : ones / tens / hundreds reel digits
//   credit                : credit balance, binary
//   credit_tens/_ones     : BCD digits of credit
//   win_code              : 0 none, 1 pair, 2 triple, 3 jackpot
//   win_valid             : one-cycle pulse when win_code/credit update
//   busy                  : high from spin accept until SHOW expires
//   no_credit             : one-cycle pulse on a spin request with credit 0
//   blink                 : win indicator LED
//   dbg_state             : current FSM state for observation
// Optional macro SLOT_JUDGE_BLINK_EN: blink toggles during SHOW instead of
// being a steady level.
module slot_judge
  import slot_pkg::*;
#(
  parameter int CREDIT_INIT = 10,
  parameter int CREDIT_MAX  = 99,
  parameter int PAIR_PAY    = 2,
  parameter int TRIPLE_PAY  = 10,
  parameter int JACKPOT_PAY = 50,
  parameter int SHOW_CYCLES = 50000000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       done,
  input  logic [3:0] slot_bcd1,
  input  logic [3:0] slot_bcd2,
  input  logic [3:0] slot_bcd3,
  output logic [6:0] credit,
  output logic [3:0] credit_tens,
  output logic [3:0] credit_ones,
  output logic [1:0] win_code,
  output logic       win_valid,
  output logic       busy,
  output logic       no_credit,
  output logic       blink,
  output state_e     dbg_state
);

  logic mode_rise, mode_fall, done_rise, done_fall_unused;

  sync_edge u_sync_mode (
    .clk  (clk),
    .rst  (rst),
    .din  (mode),
    .rise (mode_rise),
    .fall (mode_fall)
  );

  sync_edge u_sync_done (
    .clk  (clk),
    .rst  (rst),
    .din  (done),
    .rise (done_rise),
    .fall (done_fall_unused)
  );

  state_e      state_q, state_d;
  logic [6:0]  credit_q, credit_d;
  logic [1:0]  win_code_q, win_code_d;
  logic        win_valid_q, win_valid_d;
  logic        busy_q, busy_d;
  logic        no_credit_q, no_credit_d;
  logic        blink_q, blink_d;
  logic [3:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [31:0] show_cnt_q, show_cnt_d;
  logic [7:0]  pay;
  logic [7:0]  credit_sum;

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    win_code_d  = win_code_q;
    win_valid_d = 1'b0;
    busy_d      = busy_q;
    no_credit_d = 1'b0;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    show_cnt_d  = show_cnt_q;
    pay         = 8'd0;
    credit_sum  = 8'd0;

    case (state_q)
      IDLE: begin
        if (mode_rise) begin
          if (credit_q != 7'd0) begin
            credit_d = credit_q - 7'd1;
            busy_d   = 1'b1;
            state_d  = SPIN;
          end else begin
            no_credit_d = 1'b1;
          end
        end
      end
      SPIN: begin
        // done_rise takes priority over a simultaneous abort.
        if (done_rise) begin
          state_d = LATCH;
        end else if (mode_fall) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      LATCH: begin
        d1_d    = slot_bcd1;
        d2_d    = slot_bcd2;
        d3_d    = slot_bcd3;
        state_d = EVAL;
      end
      EVAL: begin
        win_code_d = classify(d1_q, d2_q, d3_q);
        case (win_code_d)
          WIN_PAIR:    pay = 8'(PAIR_PAY);
          WIN_TRIPLE:  pay = 8'(TRIPLE_PAY);
          WIN_JACKPOT: pay = 8'(JACKPOT_PAY);
          default:     pay = 8'd0;
        endcase
        // 8-bit sum so 99 + 50 cannot wrap before saturation.
        credit_sum  = {1'b0, credit_q} + pay;
        credit_d    = (credit_sum > 8'(CREDIT_MAX)) ? 7'(CREDIT_MAX)
                                                    : credit_sum[6:0];
        win_valid_d = 1'b1;
        show_cnt_d  = 32'(SHOW_CYCLES - 1);
        state_d     = SHOW;
      end
      SHOW: begin
        // mode_rise is simply not looked at here, so it is dropped.
        if (show_cnt_q == 32'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          show_cnt_d = show_cnt_q - 32'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef SLOT_JUDGE_BLINK_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic [31:0] blink_period;

  always_comb begin
    blink_period = (win_code_d == WIN_JACKPOT) ? 32'(BLINK_DIV / 4)
                                               : 32'(BLINK_DIV);
    blink_d      = 1'b0;
    blink_cnt_d  = 32'd0;
    if (state_d == SHOW && win_code_d != WIN_NONE) begin
      if (state_q != SHOW) begin
        blink_d     = 1'b1;
        blink_cnt_d = blink_period - 32'd1;
      end else if (blink_cnt_q == 32'd0) begin
        blink_d     = ~blink_q;
        blink_cnt_d = blink_period - 32'd1;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blink_cnt_q <= 32'd0;
    else     blink_cnt_q <= blink_cnt_d;
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = ^32'(BLINK_DIV);

  // Steady indicator: registered copy of "showing a winning result".
  always_comb begin
    blink_d = (state_d == SHOW) && (win_code_d != WIN_NONE);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= 7'(CREDIT_INIT);
      win_code_q  <= WIN_NONE;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      no_credit_q <= 1'b0;
      blink_q     <= 1'b0;
      d1_q        <= 4'd0;
      d2_q        <= 4'd0;
      d3_q        <= 4'd0;
      show_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      win_code_q  <= win_code_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      no_credit_q <= no_credit_d;
      blink_q     <= blink_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      show_cnt_q  <= show_cnt_d;
    end
  end

  assign credit      = credit_q;
  assign credit_tens = 4'(credit_q / 7'd10);
  assign credit_ones = 4'(credit_q % 7'd10);
  assign win_code    = win_code_q;
  assign win_valid   = win_valid_q;
  assign busy        = busy_q;
  assign no_credit   = no_credit_q;
  assign blink       = blink_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_slot_judge.sv
// Testbench for slot_judge: directed scenarios followed by randomized spins,
// each checked against a credit/win model derived from the payout rules.
module tb_slot_judge;
  import slot_pkg::*;

  localparam int CREDIT_INIT = 10;
  localparam int CREDIT_MAX  = 99;
  localparam int PAIR_PAY    = 2;
  localparam int TRIPLE_PAY  = 10;
  localparam int JACKPOT_PAY = 50;
  localparam int SHOW_CYCLES = 20;
  localparam int BLINK_DIV   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mode = 1'b0;
  logic       done = 1'b0;
  logic [3:0] slot_bcd1 = 4'd0, slot_bcd2 = 4'd0, slot_bcd3 = 4'd0;
  logic [6:0] credit;
  logic [3:0] credit_tens, credit_ones;
  logic [1:0] win_code;
  logic       win_valid, busy, no_credit, blink;
  state_e     dbg_state;

  slot_judge #(
    .CREDIT_INIT (CREDIT_INIT),
    .CREDIT_MAX  (CREDIT_MAX),
    .PAIR_PAY    (PAIR_PAY),
    .TRIPLE_PAY  (TRIPLE_PAY),
    .JACKPOT_PAY (JACKPOT_PAY),
    .SHOW_CYCLES (SHOW_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .done        (done),
    .slot_bcd1   (slot_bcd1),
    .slot_bcd2   (slot_bcd2),
    .slot_bcd3   (slot_bcd3),
    .credit      (credit),
    .credit_tens (credit_tens),
    .credit_ones (credit_ones),
    .win_code    (win_code),
    .win_valid   (win_valid),
    .busy        (busy),
    .no_credit   (no_credit),
    .blink       (blink),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int m_credit = CREDIT_INIT;
  int m_code   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_credit(input string tag);
    check({tag, " credit"}, int'(credit), m_credit);
    check({tag, " credit_tens"}, int'(credit_tens), m_credit / 10);
    check({tag, " credit_ones"}, int'(credit_ones), m_credit % 10);
  endtask

  // Reference model: count matching digit pairs.
  function automatic int model_code(input int a, input int b, input int c);
    int eq;
    if (a > 9 || b > 9 || c > 9) return 0;
    eq = int'(a == b) + int'(b == c) + int'(a == c);
    if (eq == 3) return (a == 7) ? 3 : 2;
    if (eq >= 1) return 1;
    return 0;
  endfunction

  function automatic int model_pay(input int code);
    case (code)
      1: return PAIR_PAY;
      2: return TRIPLE_PAY;
      3: return JACKPOT_PAY;
      default: return 0;
    endcase
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    mode = 1'b0;
    done = 1'b0;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
    m_credit = CREDIT_INIT;
    m_code   = 0;
  endtask

  // Full spin: request, reels settle with the given digits, SHOW expires.
  task automatic spin(input int a, input int b, input int c, input string tag);
    int nc;
    int wv;
    int n;
    int code;
    nc = 0;
    wv = 0;
    slot_bcd1 = 4'(a);
    slot_bcd2 = 4'(b);
    slot_bcd3 = 4'(c);
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (no_credit) nc++;
    end
    if (m_credit == 0) begin
      check({tag, " no_credit pulses"}, nc, 1);
      check({tag, " busy idle"}, int'(busy), 0);
      check({tag, " state idle"}, int'(dbg_state), int'(IDLE));
      check_credit({tag, " empty"});
      done = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (win_valid) wv++;
      end
      check({tag, " no win_valid"}, wv, 0);
      mode = 1'b0;
      done = 1'b0;
      step(6);
      return;
    end
    check({tag, " no_credit quiet"}, nc, 0);
    check({tag, " busy accept"}, int'(busy), 1);
    m_credit = m_credit - 1;
    check_credit({tag, " debit"});
    done = 1'b1;
    n = 0;
    while (!win_valid && n < 12) begin
      step(1);
      n++;
    end
    check({tag, " win_valid seen"}, int'(win_valid), 1);
    code = model_code(a, b, c);
    m_code = code;
    m_credit = m_credit + model_pay(code);
    if (m_credit > CREDIT_MAX) m_credit = CREDIT_MAX;
    check({tag, " win_code"}, int'(win_code), m_code);
    check_credit({tag, " payout"});
    check({tag, " blink entry"}, int'(blink), int'(code != 0));
    n = 0;
    while (busy && n < SHOW_CYCLES + 10) begin
      step(1);
      n++;
      if (win_valid) wv++;
`ifndef SLOT_JUDGE_BLINK_EN
      if (n == SHOW_CYCLES / 2)
        check({tag, " blink mid"}, int'(blink), int'(code != 0));
`endif
    end
    check({tag, " show length"}, n, SHOW_CYCLES);
    check({tag, " single win_valid"}, wv, 0);
    check({tag, " blink after"}, int'(blink), 0);
    check({tag, " win_code hold"}, int'(win_code), m_code);
    mode = 1'b0;
    done = 1'b0;
    step(6);
  endtask

  // mode rises then falls before done; later done must be ignored.
  task automatic abort_spin(input string tag);
    int wv;
    wv = 0;
    mode = 1'b1;
    step(6);
    check({tag, " busy accept"}, int'(busy), 1);
    m_credit = m_credit - 1;
    check_credit({tag, " debit"});
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (win_valid) wv++;
    end
    check({tag, " busy cleared"}, int'(busy), 0);
    done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (win_valid) wv++;
    end
    check({tag, " no win_valid"}, wv, 0);
    check({tag, " win_code kept"}, int'(win_code), m_code);
    check_credit({tag, " no refund"});
    done = 1'b0;
    step(6);
  endtask

  initial begin
    int a, b, c;

    // reset state
    do_reset();
    check_credit("reset");
    check("reset busy", int'(busy), 0);
    check("reset win_code", int'(win_code), 0);
    check("reset win_valid", int'(win_valid), 0);
    check("reset no_credit", int'(no_credit), 0);
    check("reset blink", int'(blink), 0);
    check("reset state", int'(dbg_state), int'(IDLE));

    // jackpot 10 -> 9 -> 59
    spin(7, 7, 7, "jackpot");

    // from 5: pair then nothing
    do_reset();
    for (int i = 0; i < 5; i++) abort_spin("abort_to5");
    spin(3, 5, 3, "pair");
    spin(1, 2, 4, "none");

    // drain to 0, then request with no credit
    while (m_credit > 0) abort_spin("drain");
    spin(7, 7, 7, "no_credit");

    // saturation from 95 with 4,4,4
    do_reset();
    spin(7, 7, 7, "jackpot2");
    spin(7, 7, 7, "jackpot_sat");
    while (m_credit > 95) abort_spin("down_to95");
    spin(4, 4, 4, "triple_sat");

    // randomized spins, including occasional non-BCD digits
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      b = ($urandom_range(0, 2) == 0) ? a : int'($urandom_range(0, 9));
      c = ($urandom_range(0, 3) == 0) ? b : int'($urandom_range(0, 9));
      spin(a, b, c, "random");
    end

    // reset while spinning
    do_reset();
    mode = 1'b1;
    step(6);
    check("midspin busy", int'(busy), 1);
    check("midspin state", int'(dbg_state), int'(SPIN));
    rst  = 1'b1;
    mode = 1'b0;
    step(1);
    m_credit = CREDIT_INIT;
    check_credit("midspin reset");
    check("midspin reset busy", int'(busy), 0);
    check("midspin reset state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
